// File: rtl/dsm_bitstream_decimator.sv
// CIC (sinc^N) decimator turning a 1-bit delta-sigma density stream into signed PCM.
// Optional macro DSM_DEC_WARMUP_MASK_EN suppresses o_valid for the first CIC_ORDER-1 outputs.
module dsm_bitstream_decimator #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned OSR        = 64,
   parameter int unsigned CIC_ORDER  = 2
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_bit_en,
   input  logic                  i_bit,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic                  o_valid
);

   localparam int unsigned L     = $clog2(OSR);
   localparam int unsigned W     = CIC_ORDER * L + 2;
   localparam int unsigned XW    = W + DATA_WIDTH;
   localparam int          SHIFT = int'(CIC_ORDER * L) - int'(DATA_WIDTH - 1);
   localparam int unsigned SHR   = (SHIFT > 0) ? $unsigned(SHIFT)  : 0;
   localparam int unsigned SHL   = (SHIFT < 0) ? $unsigned(-SHIFT) : 0;

   localparam logic signed [XW-1:0] MAXV = {{(XW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
   localparam logic signed [XW-1:0] MINV = ~MAXV;

   if (OSR < 4 || OSR > 256 || (OSR & (OSR - 1)) != 0) begin : g_bad_osr
      $error("OSR must be a power of two in 4..256");
   end
   if (CIC_ORDER < 1 || CIC_ORDER > 3) begin : g_bad_order
      $error("CIC_ORDER must be 1..3");
   end

   logic signed [W-1:0] step;
   logic [L-1:0]        cnt;
   logic                dec;
   logic                warm_ok;

   assign step = i_bit ? W'(1) : {W{1'b1}};

   // Integrator chain: each stage adds the freshly updated value of the previous stage.
   for (genvar k = 0; k < int'(CIC_ORDER); k++) begin : g_int
      logic signed [W-1:0] acc;
      logic signed [W-1:0] acc_nxt;

      if (k == 0) begin : g_first
         assign acc_nxt = acc + step;
      end else begin : g_rest
         assign acc_nxt = acc + g_int[k-1].acc_nxt;
      end

      always_ff @(posedge i_clk or negedge i_rst_n) begin
         if (!i_rst_n) begin
            acc <= '0;
         end else if (i_bit_en) begin
            acc <= acc_nxt;
         end
      end
   end

   // Frame counter; dec is high for the single cycle after the OSR-th accepted bit.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt <= '0;
         dec <= 1'b0;
      end else begin
         dec <= i_bit_en && (cnt == L'(OSR - 1));
         if (i_bit_en) begin
            cnt <= cnt + L'(1);
         end
      end
   end

   // Comb chain reads the registered last integrator, so a bit accepted now is not lost.
   for (genvar k = 0; k < int'(CIC_ORDER); k++) begin : g_cmb
      logic signed [W-1:0] din;
      logic signed [W-1:0] dly;
      logic signed [W-1:0] dout;

      if (k == 0) begin : g_first
         assign din = g_int[CIC_ORDER-1].acc;
      end else begin : g_rest
         assign din = g_cmb[k-1].dout;
      end
      assign dout = din - dly;

      always_ff @(posedge i_clk or negedge i_rst_n) begin
         if (!i_rst_n) begin
            dly <= '0;
         end else if (dec) begin
            dly <= din;
         end
      end
   end

   logic signed [XW-1:0]         comb_ext;
   logic signed [XW-1:0]         scaled;
   logic signed [DATA_WIDTH-1:0] sat;

   // Rescale to DATA_WIDTH full scale, then clamp.
   always_comb begin
      comb_ext = XW'(g_cmb[CIC_ORDER-1].dout);
      scaled   = (comb_ext <<< SHL) >>> SHR;
      sat      = scaled[DATA_WIDTH-1:0];
      if (scaled > MAXV) begin
         sat = MAXV[DATA_WIDTH-1:0];
      end else if (scaled < MINV) begin
         sat = MINV[DATA_WIDTH-1:0];
      end
   end

`ifdef DSM_DEC_WARMUP_MASK_EN
   localparam int unsigned WARM = CIC_ORDER - 1;
   logic [1:0] warm;

   assign warm_ok = (warm == 2'(WARM));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         warm <= '0;
      end else if (dec && !warm_ok) begin
         warm <= warm + 2'd1;
      end
   end
`else
   assign warm_ok = 1'b1;
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_data  <= '0;
         o_valid <= 1'b0;
      end else begin
         o_valid <= dec && warm_ok;
         if (dec) begin
            o_data <= sat;
         end
      end
   end

endmodule
